// File: rtl/jtvigil_sndif_if.sv
// jtvigil_sndif_if: main/sound CPU latch, interrupt and sample ROM/DAC signals of the sound interface
interface jtvigil_sndif_if #(parameter int SAMPLE_AW = 16);
  logic                 latch_wr;
  logic [7:0]           main_dout;
  logic                 snd_wr;
  logic [1:0]           snd_addr;
  logic [7:0]           snd_dout;
  logic                 ym_irq_n;
  logic [7:0]           snd_latch;
  logic                 int_n;
  logic [7:0]           int_vector;
  logic                 sample_tick;
  logic [SAMPLE_AW-1:0] sample_addr;
  logic                 sample_cs;
  logic [7:0]           sample_data;
  logic                 sample_ok;
  logic [7:0]           dac;
  modport slave (
    input  latch_wr, main_dout, snd_wr, snd_addr, snd_dout, ym_irq_n,
           sample_tick, sample_data, sample_ok,
    output snd_latch, int_n, int_vector, sample_addr, sample_cs, dac
  );
  modport master (
    output latch_wr, main_dout, snd_wr, snd_addr, snd_dout, ym_irq_n,
           sample_tick, sample_data, sample_ok,
    input  snd_latch, int_n, int_vector, sample_addr, sample_cs, dac
  );
endinterface

// File: rtl/jtvigil_sndif.sv
// jtvigil_sndif: sound latch, IM0 RST vector merge and autonomous 8-bit PCM sample player
module jtvigil_sndif #(
  parameter int         SAMPLE_AW = 16,
  parameter logic [7:0] END_MARK  = 8'h00
) (
  input logic            clk,
  input logic            rst,
  jtvigil_sndif_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT} state_t;
  state_t               state_q, state_d;
  logic                 latch_wr_q, snd_wr_q;
  logic [7:0]           latch_q, latch_d;
  logic                 pend_q, pend_d;
  logic                 int_n_q, int_n_d;
  logic [7:0]           vec_q, vec_d;
  logic [SAMPLE_AW-1:0] addr_q, addr_d;
  logic                 cs_q, cs_d;
  logic [7:0]           dac_q, dac_d;
  logic                 latch_rise, wr_rise, ack, lo_wr, hi_wr, play_wr, take;
  assign latch_rise = bus.latch_wr & ~latch_wr_q;
  assign wr_rise    = bus.snd_wr & ~snd_wr_q;
  assign ack        = wr_rise && bus.snd_addr == 2'd0;
  assign lo_wr      = wr_rise && bus.snd_addr == 2'd1;
  assign hi_wr      = wr_rise && bus.snd_addr == 2'd2;
  assign play_wr    = wr_rise && bus.snd_addr == 2'd3;
  // a register write in the same cycle as sample_ok restarts the fetch instead of consuming the byte
  assign take = state_q == FETCH && cs_q && bus.sample_ok && !lo_wr && !hi_wr && !play_wr;
  always_comb begin
    latch_d = latch_rise ? bus.main_dout : latch_q;
    pend_d  = latch_rise | (pend_q & ~ack);
    int_n_d = ~(pend_q | ~bus.ym_irq_n);
    vec_d   = {2'b11, ~pend_q, bus.ym_irq_n, 4'hF};
    state_d = state_q;
    addr_d  = addr_q;
    dac_d   = dac_q;
    if (take) begin
      state_d = bus.sample_data == END_MARK ? IDLE : WAIT;
      dac_d   = bus.sample_data == END_MARK ? 8'h80 : bus.sample_data;
      addr_d  = bus.sample_data == END_MARK ? addr_q : addr_q + 1'b1;
    end
    if (state_q == WAIT && bus.sample_tick) state_d = FETCH;
    if (lo_wr) addr_d[7:0] = bus.snd_dout;
    if (hi_wr) addr_d[SAMPLE_AW-1:8] = bus.snd_dout[SAMPLE_AW-9:0];
    if (play_wr) begin
      state_d = bus.snd_dout[0] ? FETCH : IDLE;
      dac_d   = bus.snd_dout[0] ? dac_d : 8'h80;
    end
    cs_d = state_d == FETCH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      latch_wr_q <= 1'b0;
      snd_wr_q   <= 1'b0;
      latch_q    <= 8'h00;
      pend_q     <= 1'b0;
      int_n_q    <= 1'b1;
      vec_q      <= 8'hFF;
      addr_q     <= '0;
      cs_q       <= 1'b0;
      dac_q      <= 8'h80;
    end else begin
      state_q    <= state_d;
      latch_wr_q <= bus.latch_wr;
      snd_wr_q   <= bus.snd_wr;
      latch_q    <= latch_d;
      pend_q     <= pend_d;
      int_n_q    <= int_n_d;
      vec_q      <= vec_d;
      addr_q     <= addr_d;
      cs_q       <= cs_d;
      dac_q      <= dac_d;
    end
  end
  assign bus.snd_latch   = latch_q;
  assign bus.int_n       = int_n_q;
  assign bus.int_vector  = vec_q;
  assign bus.sample_addr = addr_q;
  assign bus.sample_cs   = cs_q;
  assign bus.dac         = dac_q;
endmodule
